ifetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the combinational instruction memory read port. It holds the fetch PC and prefetches sequential words into a small queue. It hands {pc, instruction, fault} to the decode stage over a valid/ready handshake. Branch/jump redirects flush the queue, and a halt input freezes fetching.

---
 rtl/ifetch_ctrl.sv | 121 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction fetch controller with prefetch queue, redirect flush and halt
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 4,
    parameter int          IMEM_WORDS = 16384,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_instr,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       halt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_fault,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_fetch_pc;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [31:0]     r_q_pc    [DEPTH];
    logic [31:0]     r_q_instr [DEPTH];
    logic            r_q_fault [DEPTH];

    logic            w_out_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_full;
    logic            w_in_range;

    // A redirect hides the head in its own cycle, so it can never be consumed
    assign w_out_valid = (r_count != '0) & ~redirect_valid;
    assign w_pop       = w_out_valid & out_ready;
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_push      = (r_state == S_FETCH) & ~halt & ~redirect_valid & (~w_full | w_pop);
    assign w_in_range  = ({2'b00, r_fetch_pc[31:2]} < 32'(IMEM_WORDS));

    // Next state only depends on halt; BOOT exists to spend one cycle without fetching
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT:   w_next_state = halt ? S_HALTED : S_FETCH;
            S_FETCH:  w_next_state = halt ? S_HALTED : S_FETCH;
            S_HALTED: w_next_state = halt ? S_HALTED : S_FETCH;
            default:  w_next_state = S_BOOT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Fetch PC, queue pointers and occupancy; redirect flushes and wins over push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; out-of-range fetches are replaced by a NOP and flagged
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= r_fetch_pc;
            r_q_instr[r_wr_ptr] <= w_in_range ? imem_instr : NOP_INSN;
            r_q_fault[r_wr_ptr] <= ~w_in_range;
        end
    end

    assign imem_addr = r_fetch_pc;
    assign out_valid = w_out_valid;
    assign out_pc    = w_out_valid ? r_q_pc[r_rd_ptr]    : 32'd0;
    assign out_instr = w_out_valid ? r_q_instr[r_rd_ptr] : 32'd0;
    assign out_fault = w_out_valid ? r_q_fault[r_rd_ptr] : 1'b0;
    assign count     = r_count;
    assign idle      = (r_state == S_HALTED) & (r_count == '0);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - scoreboard bench for ifetch_ctrl
module tb_ifetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic [2:0]  count;
    logic        idle;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;

    ifetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault),
        .count          (count),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {4'hE, a[29:2]};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ent(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        ent_t e;
        e.pc    = pc;
        e.instr = instr;
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout actual=%0d_left required=0", exp_q.size());
            exp_q.delete();
        end
        out_ready = 1'b0;
    endtask

    // Monitor: every accepted head must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_pop actual_pc=%h required=none", out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pop_pc", out_pc, mon_e.pc);
                    check("pop_instr", out_instr, mon_e.instr);
                    check("pop_fault", {31'd0, out_fault}, {31'd0, mon_e.fault});
                end
            end else if (!out_valid) begin
                check("invalid_zero", out_pc | out_instr | {31'd0, out_fault}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        tick();
        tick();

        // Boot stream: first valid two edges after release
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_ent(32'(i * 4), mem_word(32'(i * 4)), 1'b0);
        tick();
        check("boot_no_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("boot_first_valid", {31'd0, out_valid}, 32'd1);
        check("boot_first_pc", out_pc, 32'h0);
        drain();

        // Backpressure saturation from a fresh reset
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("sat_count", {29'd0, count}, 32'd4);
        check("sat_addr", imem_addr, 32'h10);
        for (int i = 0; i < 6; i++) expect_ent(32'(i * 4), mem_word(32'(i * 4)), 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("sat_no_gap", {31'd0, out_valid}, 32'd1);
            tick();
        end
        drain();

        // Redirect with a full queue
        tick();
        tick();
        check("full_count", {29'd0, count}, 32'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        check("redir_valid_low", {31'd0, out_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("redir_flush_count", {29'd0, count}, 32'd0);
        tick();
        check("redir_target_count", {29'd0, count}, 32'd1);
        check("redir_target_pc", out_pc, 32'h100);
        expect_ent(32'h100, mem_word(32'h100), 1'b0);
        expect_ent(32'h104, mem_word(32'h104), 1'b0);
        expect_ent(32'h108, mem_word(32'h108), 1'b0);
        drain();

        // Halt with three entries queued
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        tick();
        check("halt_pre_count", {29'd0, count}, 32'd3);
        halt      = 1'b1;
        out_ready = 1'b1;
        expect_ent(32'h200, mem_word(32'h200), 1'b0);
        expect_ent(32'h204, mem_word(32'h204), 1'b0);
        expect_ent(32'h208, mem_word(32'h208), 1'b0);
        tick();
        tick();
        tick();
        check("halt_idle", {31'd0, idle}, 32'd1);
        check("halt_count", {29'd0, count}, 32'd0);
        check("halt_addr", imem_addr, 32'h20C);
        tick();
        tick();
        tick();
        check("halt_addr_frozen", imem_addr, 32'h20C);
        check("halt_scoreboard_empty", exp_q.size(), 32'd0);
        expect_ent(32'h20C, mem_word(32'h20C), 1'b0);
        expect_ent(32'h210, mem_word(32'h210), 1'b0);
        halt = 1'b0;
        drain();

        // Top of implemented memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_FFFC;
        expect_ent(32'h0000_FFFC, mem_word(32'h0000_FFFC), 1'b0);
        expect_ent(32'h0001_0000, 32'h0000_0013, 1'b1);
        expect_ent(32'h0001_0004, 32'h0000_0013, 1'b1);
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        drain();

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        expect_ent(32'hFFFF_FFFC, 32'h0000_0013, 1'b1);
        expect_ent(32'h0000_0000, mem_word(32'h0), 1'b0);
        expect_ent(32'h0000_0004, mem_word(32'h4), 1'b0);
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        drain();

        // Asynchronous reset mid-stream
        tick();
        tick();
        tick();
        check("pre_reset_count", {29'd0, count}, 32'd4);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_count", {29'd0, count}, 32'd0);
        check("async_rst_addr", imem_addr, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
